// File: rtl/alu_seq.sv
// Handshaked accumulator ALU: single-cycle ops with registered result and flags,
// plus an iterative shift-add multiply (MUL/MULH) that occupies the block for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int THRESH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             acc_zero
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int CW    = (WIDTH > 32) ? WIDTH : 32;
    localparam logic [CW-1:0] THRESH_EXT = CW'(THRESH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               mulh;

    logic               accept;
    logic               is_mul;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic [CW-1:0]      acc_ext;
    logic [WIDTH-1:0]   mul_res;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return ((a < 0) != (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    assign acc_zero = (accum == '0);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (opcode == OP_MUL) || (opcode == OP_MULH);
    assign acc_ext  = CW'(accum);
    assign mul_res  = mulh ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];

    always_comb begin
        sum   = {1'b0, accum} + {1'b0, data};
        diff  = accum - data;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (opcode)
            4'd0: res = accum;
            4'd1: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = add_ovf(accum, data, sum[WIDTH-1:0]);
            end
            4'd2: begin
                res   = diff;
                res_c = (accum < data);
                res_v = sub_ovf(accum, data, diff);
            end
            4'd3: res = accum & data;
            4'd4: res = accum ^ data;
            4'd5: res = accum | data;
            4'd6: res = ~accum + 1'b1;
            4'd7: res = (acc_ext >= THRESH_EXT) ? data : ~data;
            4'd8: res = accum << data[SH_W-1:0];
            4'd9: res = accum >> data[SH_W-1:0];
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            alu_out   <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            neg       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state   <= S_BUSY;
                            count   <= '0;
                            product <= '0;
                        end else begin
                            alu_out   <= res;
                            zero      <= (res == '0);
                            carry     <= res_c;
                            ovf       <= res_v;
                            neg       <= res[WIDTH-1];
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (mplier[count]) begin
                        product <= product + ({{WIDTH{1'b0}}, mcand} << count);
                    end
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Waits here while the previous result is still unconsumed.
                    if (!out_valid || out_ready) begin
                        alu_out   <= mul_res;
                        zero      <= (mul_res == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        neg       <= mul_res[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Multiply operands are only meaningful after a MUL/MULH accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand  <= accum;
            mplier <= data;
            mulh   <= (opcode == OP_MULH);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expected results queued on accept, compared on drain.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = 4'd0;
    logic [7:0] accum = 8'd0;
    logic [7:0] data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] alu_out;
    logic       zero, carry, ovf, neg, acc_zero;

    int n_chk = 0;
    int n_pass = 0;
    logic [11:0] sb[$];
    logic [11:0] sb_exp;
    logic rand_bp = 1'b0;

    alu_seq #(.WIDTH(8), .THRESH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .accum(accum), .data(data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .zero(zero), .carry(carry),
        .ovf(ovf), .neg(neg), .acc_zero(acc_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // {alu_out, zero, carry, ovf, neg}
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  r;
        logic        c, v;
        logic [8:0]  s;
        logic [15:0] p;
        c = 1'b0;
        v = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        p = 16'(a) * 16'(b);
        case (op)
            4'd0: r = a;
            4'd1: begin r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd2: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd3: r = a & b;
            4'd4: r = a ^ b;
            4'd5: r = a | b;
            4'd6: r = 8'(9'd256 - {1'b0, a});
            4'd7: r = (a >= 8'd32) ? b : ~b;
            4'd8: r = a << b[2:0];
            4'd9: r = a >> b[2:0];
            4'd10: r = p[7:0];
            4'd11: r = p[15:8];
            default: r = 8'd0;
        endcase
        return {r, (r == 8'd0), c, v, r[7]};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra", 32'(1), 32'(0));
                end else begin
                    sb_exp = sb.pop_front();
                    chk("sb_res", 32'({alu_out, zero, carry, ovf, neg}), 32'(sb_exp));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(opcode, accum, data));
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited;
        in_valid = 1'b1;
        opcode = op;
        accum = a;
        data = b;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                chk("send_timeout", 32'(0), 32'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        logic rdy_seen;
        logic stale;

        // Reset state and combinational acc_zero while in reset
        #2;
        chk("rst_outs", 32'({out_valid, alu_out, zero, carry, ovf, neg}), 32'(0));
        accum = 8'h00; #1;
        chk("acc_zero_rst", 32'(acc_zero), 32'(1));
        accum = 8'h05; #1;
        chk("acc_zero_rst_nz", 32'(acc_zero), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", 32'(in_ready), 32'(1));

        // ADD latency and flags
        send(4'd1, 8'hF0, 8'h20);
        chk("add_vld", 32'(out_valid), 32'(1));
        chk("add_res", 32'({alu_out, zero, carry, ovf, neg}), 32'({8'h10, 1'b0, 1'b1, 1'b0, 1'b0}));
        send(4'd1, 8'h7F, 8'h01);
        chk("add_ovf", 32'({alu_out, ovf, neg}), 32'({8'h80, 1'b1, 1'b1}));
        send(4'd2, 8'h10, 8'h20);
        chk("sub_brw", 32'({alu_out, carry, neg}), 32'({8'hF0, 1'b1, 1'b1}));
        send(4'd7, 8'h20, 8'h0F);
        chk("sel_hi", 32'(alu_out), 32'(8'h0F));
        send(4'd7, 8'h1F, 8'h0F);
        chk("sel_lo", 32'(alu_out), 32'(8'hF0));
        send(4'd13, 8'hFF, 8'hFF);
        chk("op13", 32'({alu_out, zero, carry, ovf, neg}), 32'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0}));
        send(4'd6, 8'h00, 8'h00);
        chk("neg0", 32'({alu_out, zero}), 32'({8'h00, 1'b1}));
        send(4'd8, 8'h81, 8'h0B);
        chk("shl", 32'(alu_out), 32'(8'h08));
        send(4'd9, 8'h81, 8'hF9);
        chk("shr", 32'(alu_out), 32'(8'h40));
        send(4'd0, 8'hA5, 8'h00);
        send(4'd3, 8'hF0, 8'h3C);
        send(4'd4, 8'hF0, 8'h3C);
        send(4'd5, 8'hF0, 8'h3C);
        send(4'd6, 8'h05, 8'h00);
        send(4'd15, 8'h12, 8'h34);

        // MUL latency, in_ready low while busy
        send(4'd10, 8'h40, 8'h08);
        chk("mul_busy_rdy", 32'(in_ready), 32'(0));
        cyc = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 50) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mul_lat", 32'(cyc), 32'(9));
        chk("mul_rdy_low", 32'(rdy_seen), 32'(0));
        chk("mul_res", 32'({alu_out, zero}), 32'({8'h00, 1'b1}));
        send(4'd11, 8'h40, 8'h08);
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("mulh_res", 32'(alu_out), 32'(8'h02));
        send(4'd10, 8'hFF, 8'hFF);
        send(4'd11, 8'hFF, 8'hFF);
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("mulh_ff", 32'(alu_out), 32'(8'hFE));
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-BUSY abandons the multiply
        send(4'd10, 8'h13, 8'h07);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy_outs", 32'({out_valid, alu_out, zero, carry, ovf, neg}), 32'(0));
        accum = 8'h00; #1;
        chk("acc_zero_rst2", 32'(acc_zero), 32'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst2", 32'(in_ready), 32'(1));
        stale = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale", 32'(stale), 32'(0));

        // acc_zero with in_valid low
        accum = 8'h00; #1;
        chk("acc_zero", 32'(acc_zero), 32'(1));
        accum = 8'h80; #1;
        chk("acc_zero_nz", 32'(acc_zero), 32'(0));

        // Backpressure: first result held, second accepted on the drain cycle
        out_ready = 1'b0;
        send(4'd1, 8'h11, 8'h22);
        in_valid = 1'b1; opcode = 4'd1; accum = 8'h40; data = 8'h05;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold", 32'({out_valid, alu_out}), 32'({1'b1, 8'h33}));
            chk("bp_rdy", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_second", 32'({out_valid, alu_out}), 32'({1'b1, 8'h45}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Random ops under random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
